// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes and FSM state type for the data-memory responder
package dmem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane merge for stores, extract/extend for loads, access error check
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] old_word_i,
   output logic [31:0] new_word_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic [31:0] shifted;
   logic [31:0] ext;
   logic        size_err;
   logic        range_err;

   always_comb begin
      shifted   = old_word_i >> {addr_i[1:0], 3'b000};
      range_err = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
      size_err  = 1'b0;
      ext       = 32'h0;
      new_word_o = old_word_i;
      case (size_i)
         SZ_B: begin
            ext = {{24{shifted[7]}}, shifted[7:0]};
            new_word_o[{addr_i[1:0], 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_H: begin
            size_err = addr_i[0];
            ext = {{16{shifted[15]}}, shifted[15:0]};
            new_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         SZ_W: begin
            size_err = (addr_i[1:0] != 2'b00);
            ext = old_word_i;
            new_word_o = wdata_i;
         end
         // Unsigned sizes only make sense for loads.
         SZ_BU: begin
            size_err = we_i;
            ext = {24'h0, shifted[7:0]};
         end
         SZ_HU: begin
            size_err = we_i | addr_i[0];
            ext = {16'h0, shifted[15:0]};
         end
         default: size_err = 1'b1;
      endcase
      err_o   = size_err | range_err;
      rdata_o = (err_o || we_i) ? 32'h0 : ext;
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with req/rsp valid/ready handshakes
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] mem_q [DEPTH_WORDS];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [AW-1:0] widx;
   logic [31:0]   old_word;
   logic [31:0]   new_word;
   logic [31:0]   ld_data;
   logic          acc_err;
   logic          commit;

   assign widx     = addr_q[AW+1:2];
   assign old_word = mem_q[widx];

   dmem_lane_align #(.DEPTH_WORDS(DEPTH_WORDS)) u_align (
      .we_i       (we_q),
      .addr_i     (addr_q),
      .size_i     (size_q),
      .wdata_i    (wdata_q),
      .old_word_i (old_word),
      .new_word_o (new_word),
      .rdata_o    (ld_data),
      .err_o      (acc_err)
   );

   assign commit = (state_q == BUSY) && (cnt_q == 4'd0) && we_q && !acc_err;

   // Storage is intentionally outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (commit) mem_q[widx] <= new_word;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               cnt_d   = 4'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               rdata_d = ld_data;
               err_d   = acc_err;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         size_q  <= 3'b000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = rst_n && (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic rdy,
                       output logic [31:0] rdata, output logic err, output int lat);
      int n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
      req_valid = 1'b1; rsp_ready = rdy;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'b1; req_addr = 32'hFFFF_FFFF; req_size = 3'b111; req_wdata = 32'h5A5A_5A5A;
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         if (rsp_valid) break;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      if (rdy) @(posedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(v.we, v.addr, v.size, v.wdata, 1'b1, rd, er, lat);
      check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
      check($sformatf("v%0d_err", idx), 32'(er), 32'(v.exp_err));
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(LAT));
   endtask

   initial begin
      logic [31:0] rd, held;
      logic        er;
      int          lat;
      vec_t        v;

      vecs.push_back('{1'b1, 32'h0000_0000, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_03FC, 3'b010, 32'h0BAD_C0DE, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0011, 3'b000, 32'h0000_00A5, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b010, 32'h0,         32'hDEAD_A5EF, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0011, 3'b000, 32'h0,         32'hFFFF_FFA5, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0011, 3'b100, 32'h0,         32'h0000_00A5, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b000, 32'h0,         32'hFFFF_FFEF, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0013, 3'b000, 32'h0,         32'hFFFF_FFDE, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0012, 3'b001, 32'h0,         32'hFFFF_DEAD, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b101, 32'h0,         32'h0000_A5EF, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0022, 3'b001, 32'h0000_8001, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0022, 3'b001, 32'h0,         32'hFFFF_8001, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0022, 3'b101, 32'h0,         32'h0000_8001, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0021, 3'b001, 32'h0,         32'h0, 1'b1});
      vecs.push_back('{1'b1, 32'h0000_0400, 3'b010, 32'h1234_5678, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h0000_0000, 3'b010, 32'h0,         32'hCAFE_F00D, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_03FC, 3'b010, 32'h0,         32'h0BAD_C0DE, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0012, 3'b010, 32'h7777_7777, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b011, 32'h0,         32'h0, 1'b1});
      vecs.push_back('{1'b1, 32'h0000_0010, 3'b100, 32'h0000_0033, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h0000_0010, 3'b010, 32'h0,         32'hDEAD_A5EF, 1'b0});

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Response back-pressure: output must hold and nothing new may be accepted.
      xact(1'b0, 32'h10, 3'b010, 32'h0, 1'b0, rd, er, lat);
      check("stall_latency", 32'(lat), 32'(LAT));
      check("stall_first_rdata", rd, 32'hDEAD_A5EF);
      held = rd;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h5555_5555;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
         check($sformatf("stall%0d_rdata", c), rsp_rdata, held);
         check($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      check("after_hs_req_ready", 32'(req_ready), 32'd1);
      v = '{1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD_A5EF, 1'b0};
      run_vec(v, 100);

      // Reset during BUSY drops the second store.
      v = '{1'b1, 32'h20, 3'b010, 32'h1111_1111, 32'h0, 1'b0};
      run_vec(v, 101);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h2222_2222;
      req_valid = 1'b1;
      for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_rdata", rsp_rdata, 32'h0);
      check("midrst_rsp_err", 32'(rsp_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{1'b0, 32'h20, 3'b010, 32'h0, 32'h1111_1111, 1'b0};
      run_vec(v, 102);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
